// File: rtl/command_issuer_pkg.sv
// Shared command types for the command/syscall interface: command layout,
// opcode encodings and the issuer FSM state encoding.
package alu_cmd_pkg;

   // 12-bit command word: {op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]}
   typedef struct packed {
      logic [2:0] op;
      logic [2:0] addr1;
      logic [2:0] addr2;
      logic [2:0] addr3;
   } cmd_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MOV = 3'b101;
   localparam logic [2:0] OP_LD  = 3'b110;
   localparam logic [2:0] OP_CAS = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      WAIT  = 2'd3
   } issuer_state_e;

endpackage

// File: rtl/command_issuer_if.sv
// Bus bundle between the host/sequencer, the issuer and the controller.
//
// Handshakes:
//   host -> issuer : a command transfers on a rising clk edge where
//                    in_valid && in_ready; in_ready depends only on registered
//                    state, never on in_valid. flush discards all queued entries.
//   issuer -> ctrl : syscall is a one-cycle pulse marking a new command; command
//                    stays stable until the controller raises ctrl_ready, which is
//                    only honoured after the minimum hold window has elapsed.
interface command_issuer_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic [11:0]              in_cmd;
   logic                     in_ready;
   logic                     flush;
   logic [11:0]              command;
   logic                     syscall;
   logic                     ctrl_ready;
   logic                     busy;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic [15:0]              issued_count;
   logic                     timeout_err;

   // issuer side
   modport master (
      input  in_valid, in_cmd, flush, ctrl_ready,
      output in_ready, command, syscall, busy, fifo_count, issued_count, timeout_err
   );

   // host/controller side
   modport slave (
      output in_valid, in_cmd, flush, ctrl_ready,
      input  in_ready, command, syscall, busy, fifo_count, issued_count, timeout_err
   );
endinterface

// File: rtl/command_issuer_fifo.sv
// Small synchronous FIFO holding queued host commands. Push is gated by the
// registered not-full flag; flush empties the queue and drops a same-cycle push.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [W-1:0]           o_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_push;

   // full-ness comes from the registered count, so a pop never frees a slot
   // for a push in the same cycle
   assign o_ready = (r_count < CW'(DEPTH));
   assign w_push  = i_push && o_ready;
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;

   // storage write; a flushed push never lands
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/command_issuer.sv
// Initiator side of the command/syscall interface: queues host commands and
// issues them one at a time with a one-cycle syscall pulse, a minimum hold
// window (longer for CAS) and a bounded wait for ctrl_ready.
module command_issuer
   import alu_cmd_pkg::*;
#(
   parameter int         DEPTH      = 4,
   parameter logic [2:0] CAS_OPCODE = OP_CAS,
   parameter int         HOLD_ALU   = 1,
   parameter int         HOLD_CAS   = 2,
   parameter int         TIMEOUT    = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   command_issuer_if.master bus,
   output issuer_state_e    o_dbg_state
);
   localparam int HMAX = (HOLD_CAS > HOLD_ALU) ? HOLD_CAS : HOLD_ALU;
   localparam int HW   = ($clog2(HMAX + 1) > 0) ? $clog2(HMAX + 1) : 1;
   localparam int TW   = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

   issuer_state_e          r_state;
   issuer_state_e          w_next;
   cmd_t                   r_command;
   logic                   r_syscall;
   logic                   r_busy;
   logic [15:0]            r_issued;
   logic                   r_terr;
   logic [HW-1:0]          r_hold;
   logic [HW-1:0]          w_hold_nxt;
   logic [TW-1:0]          r_tmo;
   logic [TW-1:0]          w_tmo_nxt;
   logic                   w_pop;
   logic                   w_done;
   logic                   w_tmo_fire;
   logic [11:0]            w_head;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_in_ready;

   cmd_fifo #(.DEPTH(DEPTH), .W(12)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.in_valid),
      .i_data  (bus.in_cmd),
      .i_pop   (w_pop),
      .i_flush (bus.flush),
      .o_data  (w_head),
      .o_count (w_count),
      .o_ready (w_in_ready)
   );

   assign bus.in_ready     = w_in_ready;
   assign bus.fifo_count   = w_count;
   assign bus.command      = r_command;
   assign bus.syscall      = r_syscall;
   assign bus.busy         = r_busy;
   assign bus.issued_count = r_issued;
   assign bus.timeout_err  = r_terr;
   assign o_dbg_state      = r_state;

   // next-state, hold/timeout counter updates and pop/complete strobes
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_hold_nxt = r_hold;
      w_tmo_nxt  = r_tmo;
      w_done     = 1'b0;
      w_tmo_fire = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_count != '0) begin
               w_pop  = 1'b1;
               w_next = ISSUE;
            end
         end
         ISSUE: begin
            w_hold_nxt = (r_command.op == CAS_OPCODE) ? HW'(HOLD_CAS) : HW'(HOLD_ALU);
            w_next     = HOLD;
         end
         HOLD: begin
            // ctrl_ready is deliberately ignored until the hold window expires
            w_hold_nxt = r_hold - 1'b1;
            if (r_hold <= HW'(1)) begin
               w_next    = WAIT;
               w_tmo_nxt = TW'(TIMEOUT);
            end
         end
         WAIT: begin
            if (bus.ctrl_ready) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else if (r_tmo == '0) begin
               w_tmo_fire = 1'b1;
               w_next     = IDLE;
            end else begin
               w_tmo_nxt = r_tmo - 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // state, counters and registered interface outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_command <= '0;
         r_syscall <= 1'b0;
         r_busy    <= 1'b0;
         r_issued  <= '0;
         r_terr    <= 1'b0;
         r_hold    <= '0;
         r_tmo     <= '0;
      end else begin
         r_state   <= w_next;
         r_hold    <= w_hold_nxt;
         r_tmo     <= w_tmo_nxt;
         r_syscall <= (w_next == ISSUE);
         r_busy    <= (w_next != IDLE);
         // command is only replaced by the next pop, so it stays put in IDLE
         if (w_pop)      r_command <= w_head;
         if (w_done)     r_issued  <= r_issued + 16'd1;
         if (w_tmo_fire) r_terr    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_command_issuer.sv
// Directed bench for command_issuer: reset values, single ALU and CAS issue
// timing, FIFO full/backpressure, timeout, flush during flight, and reset in HOLD.
module tb_command_issuer;
   import alu_cmd_pkg::*;

   logic          clk;
   logic          rst_n;
   issuer_state_e dbg_state;
   int            n_cmp;
   int            n_err;
   int            pulse_cnt;
   logic          sys_prev;

   command_issuer_if #(.DEPTH(4)) bus();

   command_issuer #(
      .DEPTH(4), .CAS_OPCODE(3'b111), .HOLD_ALU(1), .HOLD_CAS(2), .TIMEOUT(15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counts syscall rising edges using pre-edge values
   initial begin
      pulse_cnt = 0;
      sys_prev  = 1'b0;
   end
   always @(posedge clk) begin
      if (bus.syscall === 1'b1 && sys_prev !== 1'b1) pulse_cnt++;
      sys_prev = bus.syscall;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got no-finish want finish-by-100us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [11:0] c);
      bus.in_valid = 1'b1;
      bus.in_cmd   = c;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int p0;
      int i0;
      int exp_cnt[6];
      int exp_rdy[6];
      n_cmp = 0;
      n_err = 0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_cmd     = '0;
      bus.flush      = 1'b0;
      bus.ctrl_ready = 1'b1;

      // reset values
      #3;
      chk("rst_command", 32'(bus.command), 32'h0);
      chk("rst_syscall", 32'(bus.syscall), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
      chk("rst_issued", 32'(bus.issued_count), 32'h0);
      chk("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rel_state", 32'(dbg_state), 32'(IDLE));

      // single ADD with ctrl_ready high
      push(12'h0D1);
      chk("add_count1", 32'(bus.fifo_count), 32'd1);
      chk("add_sys_pre", 32'(bus.syscall), 32'h0);
      tick();
      chk("add_sys_issue", 32'(bus.syscall), 32'h1);
      chk("add_command", 32'(bus.command), 32'h0D1);
      chk("add_busy_issue", 32'(bus.busy), 32'h1);
      chk("add_count0", 32'(bus.fifo_count), 32'd0);
      tick();
      chk("add_sys_hold", 32'(bus.syscall), 32'h0);
      chk("add_state_hold", 32'(dbg_state), 32'(HOLD));
      chk("add_busy_hold", 32'(bus.busy), 32'h1);
      tick();
      chk("add_state_wait", 32'(dbg_state), 32'(WAIT));
      chk("add_busy_wait", 32'(bus.busy), 32'h1);
      chk("add_issued_wait", 32'(bus.issued_count), 32'd0);
      tick();
      chk("add_busy_idle", 32'(bus.busy), 32'h0);
      chk("add_issued", 32'(bus.issued_count), 32'd1);
      chk("add_cmd_held", 32'(bus.command), 32'h0D1);

      // CAS: two HOLD cycles before WAIT
      push(12'hE53);
      tick();
      chk("cas_sys", 32'(bus.syscall), 32'h1);
      chk("cas_state_issue", 32'(dbg_state), 32'(ISSUE));
      chk("cas_command", 32'(bus.command), 32'hE53);
      tick();
      chk("cas_hold1", 32'(dbg_state), 32'(HOLD));
      chk("cas_sys_low", 32'(bus.syscall), 32'h0);
      tick();
      chk("cas_hold2", 32'(dbg_state), 32'(HOLD));
      tick();
      chk("cas_wait", 32'(dbg_state), 32'(WAIT));
      chk("cas_issued_wait", 32'(bus.issued_count), 32'd1);
      tick();
      chk("cas_idle", 32'(dbg_state), 32'(IDLE));
      chk("cas_issued", 32'(bus.issued_count), 32'd2);

      // FIFO full: 6 back-to-back pushes with controller stalled
      exp_cnt = '{1, 1, 2, 3, 4, 4};
      exp_rdy = '{1, 1, 1, 1, 0, 0};
      bus.ctrl_ready = 1'b0;
      p0 = pulse_cnt;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_cmd   = 12'h101 + 12'(i);
         tick();
         chk($sformatf("full_count%0d", i), 32'(bus.fifo_count), 32'(exp_cnt[i]));
         chk($sformatf("full_ready%0d", i), 32'(bus.in_ready), 32'(exp_rdy[i]));
      end
      bus.in_valid   = 1'b0;
      bus.ctrl_ready = 1'b1;
      repeat (30) tick();
      chk("full_pulses", 32'(pulse_cnt - p0), 32'd5);
      chk("full_issued", 32'(bus.issued_count), 32'd7);
      chk("full_last_cmd", 32'(bus.command), 32'h105);
      chk("full_drained", 32'(bus.fifo_count), 32'd0);
      chk("full_no_tmo", 32'(bus.timeout_err), 32'h0);

      // timeout: err visible 18 cycles after ISSUE
      bus.ctrl_ready = 1'b0;
      i0 = 32'(bus.issued_count);
      push(12'h040);
      tick();
      chk("tmo_sys", 32'(bus.syscall), 32'h1);
      repeat (17) tick();
      chk("tmo_err_pre", 32'(bus.timeout_err), 32'h0);
      chk("tmo_state_wait", 32'(dbg_state), 32'(WAIT));
      tick();
      chk("tmo_err", 32'(bus.timeout_err), 32'h1);
      chk("tmo_state_idle", 32'(dbg_state), 32'(IDLE));
      chk("tmo_issued_same", 32'(bus.issued_count), 32'(i0));
      bus.ctrl_ready = 1'b1;
      push(12'h0A5);
      repeat (6) tick();
      chk("tmo_next_cmd", 32'(bus.command), 32'h0A5);
      chk("tmo_next_issued", 32'(bus.issued_count), 32'(i0 + 1));
      chk("tmo_err_sticky", 32'(bus.timeout_err), 32'h1);

      // flush with 3 queued and one in WAIT
      bus.ctrl_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_cmd   = 12'h201 + 12'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("fl_count3", 32'(bus.fifo_count), 32'd3);
      chk("fl_state_wait", 32'(dbg_state), 32'(WAIT));
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl_count0", 32'(bus.fifo_count), 32'd0);
      chk("fl_inflight", 32'(dbg_state), 32'(WAIT));
      p0 = pulse_cnt;
      i0 = 32'(bus.issued_count);
      bus.ctrl_ready = 1'b1;
      repeat (10) tick();
      chk("fl_no_pulses", 32'(pulse_cnt - p0), 32'd0);
      chk("fl_issued", 32'(bus.issued_count), 32'(i0 + 1));
      chk("fl_cmd", 32'(bus.command), 32'h201);

      // reset while in HOLD
      bus.in_valid = 1'b1;
      bus.in_cmd   = 12'h0D1;
      tick();
      bus.in_cmd   = 12'h0D2;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("rh_state_hold", 32'(dbg_state), 32'(HOLD));
      chk("rh_count1", 32'(bus.fifo_count), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rh_syscall", 32'(bus.syscall), 32'h0);
      chk("rh_busy", 32'(bus.busy), 32'h0);
      chk("rh_fifo", 32'(bus.fifo_count), 32'd0);
      chk("rh_issued", 32'(bus.issued_count), 32'd0);
      chk("rh_state", 32'(dbg_state), 32'(IDLE));
      chk("rh_tmo", 32'(bus.timeout_err), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rh_in_ready", 32'(bus.in_ready), 32'h1);
      p0 = pulse_cnt;
      push(12'h3C8);
      repeat (8) tick();
      chk("rh_after_issued", 32'(bus.issued_count), 32'd1);
      chk("rh_after_cmd", 32'(bus.command), 32'h3C8);
      chk("rh_after_pulse", 32'(pulse_cnt - p0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/command_issuer.md
Name: command_issuer

Overview:
- Initiator side of the 12-bit command/syscall interface. Buffers host commands in a small FIFO and presents them one at a time on `command`.
- Fires a one-cycle `syscall` pulse per command, then holds the command stable until the register/ALU controller reports `ctrl_ready`.
- Sits between the host/test sequencer and the controller. Guarantees a clean rising edge per command and enforces the longer hold window needed by CAS.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CAS_OPCODE, 3'b111: opcode in `command[11:9]` that selects compare-and-swap.
- HOLD_ALU, 1: minimum post-pulse hold cycles for non-CAS commands.
- HOLD_CAS, 2: minimum post-pulse hold cycles for CAS.
- TIMEOUT, 15: cycles allowed after the hold window for `ctrl_ready` to be seen high.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  host offers `in_cmd`
- in_cmd  in  12  fields {op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]}
- in_ready  out  1  FIFO can accept this cycle
- flush  in  1  drop all queued (not in-flight) commands
- command  out  12  command to controller, registered
- syscall  out  1  one-cycle run pulse, registered
- ctrl_ready  in  1  controller idle/complete
- busy  out  1  command in flight (ISSUE/HOLD/WAIT)
- fifo_count  out  $clog2(DEPTH)+1  queued entries
- issued_count  out  16  completed commands, wraps 16'hFFFF to 0
- timeout_err  out  1  sticky; set on a timeout, cleared only by reset

Behaviour:
- Reset (async, `rst_n`=0):
  - `command`=0, `syscall`=0, `busy`=0, `fifo_count`=0, `issued_count`=0, `timeout_err`=0.
  - `in_ready`=1 after release.
  - FSM goes to IDLE immediately, mid-operation included; the in-flight command is abandoned.
- FIFO:
  - Push when `in_valid && in_ready`.
  - `in_ready` = (`fifo_count` < DEPTH), taken from registered count. When full, a same-cycle pop does not free a push slot.
  - Pop occurs only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- `flush`:
  - Clears the FIFO (count=0, pointers reset); a push in the same cycle is discarded.
  - Does not affect the in-flight command.
  - A pop in the same cycle as `flush` has priority: the popped entry issues.
- FSM states:
  - IDLE: `syscall`=0. If `fifo_count`>0, pop into `command`, go ISSUE.
  - ISSUE, one cycle: `syscall`=1, `command` stable. Load the hold counter with HOLD_CAS if `command[11:9]`==CAS_OPCODE, else HOLD_ALU. Go HOLD.
  - HOLD: `syscall`=0; decrement the counter; when it reaches 0, go WAIT and load the timeout counter with TIMEOUT. `ctrl_ready` is ignored here.
  - WAIT:
    - If `ctrl_ready`=1: `issued_count`++, go IDLE.
    - Else if the timeout counter is 0: set `timeout_err`, go IDLE without incrementing.
    - Else decrement.
- `command` holds its value from ISSUE until the next ISSUE; it is not cleared in IDLE.
- `syscall` is low for at least HOLD+1 cycles between pulses, so every command produces a distinct rising edge.
- Back-to-back minimum spacing for non-CAS with `ctrl_ready` tied high: ISSUE, HOLD, WAIT, IDLE, ISSUE, i.e. pulses 4 cycles apart.
- `busy`=1 in ISSUE, HOLD and WAIT.

Decomposition:
- Shared package `alu_cmd_pkg`:
  - `cmd_t` packed struct {op, addr1, addr2, addr3}.
  - Opcode localparams, including OP_CAS=3'b111.
  - `issuer_state_e` enum {IDLE, ISSUE, HOLD, WAIT}.
- One sub-module `cmd_fifo`: parameterised sync FIFO with push/pop/flush/count.

Test Plan:
- Single ADD, `ctrl_ready`=1: push 12'h0D1 -> `command`=12'h0D1 the cycle after pop, `syscall` high exactly 1 cycle, `issued_count`=1, `busy` high 3 cycles.
- CAS hold: push 12'hE53 with `ctrl_ready` held high -> `syscall` pulse, then 2 HOLD cycles before WAIT, completion on cycle 5 after pop, `issued_count`=1.
- FIFO full: push 6 commands back-to-back while `ctrl_ready`=0 -> `in_ready`=0 once 4 are queued, excess rejected, `fifo_count`=4. Release `ctrl_ready` -> exactly 5 `syscall` pulses (1 in flight + 4 queued), each on a separate rising edge.
- Timeout: push 12'h040, hold `ctrl_ready`=0 -> `timeout_err`=1 at cycle 1+HOLD_ALU+TIMEOUT+1 after ISSUE, `issued_count` unchanged, next command still issues.
- Flush mid-flight: 3 queued plus one in WAIT, assert `flush` -> `fifo_count`=0 next cycle, in-flight command completes, `issued_count`+1, no further pulses.
- Reset in HOLD: drop `rst_n` -> `syscall`, `busy`, `fifo_count` and `issued_count` all 0 asynchronously; after release a fresh push issues normally.
